// File: rtl/lc3_mem_ctrl.sv
// LC-3 load/store sequencer: direct, indirect accesses to single-port SRAM; rsp after 2/3/4/5 cycles, req_ready only in IDLE, no rsp backpressure.
// Optional user-mode access protection enabled by defining LC3_MEM_PROT_EN.
module lc3_mem_ctrl #(
    parameter logic [15:0] SYS_TOP = 16'h2FFF,
    parameter logic [15:0] IO_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_priv,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_WRI = 2'b11;

    typedef enum logic [2:0] {IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        viol_acc1, viol_ptr;

`ifdef LC3_MEM_PROT_EN
    logic priv_q, priv_d;

    // The pointer is checked as it arrives so a forbidden ACC2 is never issued.
    assign viol_acc1 = priv_q && ((addr_q <= SYS_TOP) || (addr_q >= IO_BASE));
    assign viol_ptr  = priv_q && ((mem_rdata <= SYS_TOP) || (mem_rdata >= IO_BASE));

    always_ff @(posedge clk) begin
        if (rst) priv_q <= 1'b0;
        else     priv_q <= priv_d;
    end

    always_comb begin
        priv_d = priv_q;
        if (state_q == IDLE && req_valid) priv_d = req_priv;
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{req_priv, SYS_TOP, IO_BASE};
    assign viol_acc1  = 1'b0;
    assign viol_ptr   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            ptr_q      <= 16'h0000;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    // Response registers load only on entry to RESP so they hold between responses.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ptr_d      = ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ACC1;
                end
            end
            ACC1: begin
                if (viol_acc1) begin
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                    if (op_q == OP_WR) begin
                        mem_we     = 1'b1;
                        mem_wdata  = wdata_q;
                        rsp_data_d = 16'h0000;
                        rsp_err_d  = 1'b0;
                        state_d    = RESP;
                    end else begin
                        state_d = WAIT1;
                    end
                end
            end
            WAIT1: begin
                if (op_q == OP_RD) begin
                    rsp_data_d = mem_rdata;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (viol_ptr) begin
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    ptr_d   = mem_rdata;
                    state_d = ACC2;
                end
            end
            ACC2: begin
                mem_en   = 1'b1;
                mem_addr = ptr_q;
                if (op_q == OP_WRI) begin
                    mem_we     = 1'b1;
                    mem_wdata  = wdata_q;
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                rsp_data_d = mem_rdata;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: vector table through a scoreboard plus reset/back-to-back/ready sequences.
// Expectations follow LC3_MEM_PROT_EN when it is defined.
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        req_priv = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    lc3_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_priv(req_priv),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: read data registered one cycle after the strobe; contents seeded on reset.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (rst) begin
            mem[16'h3000] <= 16'h1234;
            mem[16'h3010] <= 16'h4000;
            mem[16'h3020] <= 16'h5000;
            mem[16'h5000] <= 16'hA5A5;
            mem[16'h3030] <= 16'h0000;
            mem[16'h0000] <= 16'h7777;
            mem[16'hFFFF] <= 16'hC3C3;
            mem[16'h3040] <= 16'hFE04;
            mem[16'hFE04] <= 16'hFEFE;
            mem[16'h3050] <= 16'hFFFF;
            mem[16'h0200] <= 16'h0202;
            mem_rdata     <= 16'h0000;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          rsp_cyc;
        int          strobes;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        priv;
        logic [15:0] data;
        logic        err;
        int          lat;
        int          strobes;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;
    int   total_strobes = 0;
    int   base_strobes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_en) total_strobes++;
            if (rst) begin
                base_strobes = total_strobes;
            end else if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_cycle", cyc, e.rsp_cyc);
                    chk("strobes", total_strobes - base_strobes, e.strobes);
                    base_strobes = total_strobes;
                end
            end
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic priv, input logic [15:0] data, input logic err,
                        input int lat, input int strobes);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_priv  = priv;
        sbq.push_back('{data, err, cyc + lat, strobes});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // op, addr, wdata, priv, exp data, exp err, latency, strobes
        vt.push_back('{2'd0, 16'h3000, 16'h0000, 1'b0, 16'h1234, 1'b0, 3, 1});
        vt.push_back('{2'd1, 16'h3100, 16'h5555, 1'b0, 16'h0000, 1'b0, 2, 1});
        vt.push_back('{2'd0, 16'h3100, 16'h0000, 1'b0, 16'h5555, 1'b0, 3, 1});
        vt.push_back('{2'd3, 16'h3010, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 4, 2});
        vt.push_back('{2'd0, 16'h4000, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 3, 1});
        vt.push_back('{2'd2, 16'h3020, 16'h0000, 1'b0, 16'hA5A5, 1'b0, 5, 2});
        vt.push_back('{2'd2, 16'h3030, 16'h0000, 1'b0, 16'h7777, 1'b0, 5, 2});
        vt.push_back('{2'd0, 16'hFFFF, 16'h0000, 1'b0, 16'hC3C3, 1'b0, 3, 1});
        vt.push_back('{2'd1, 16'hFFFF, 16'h1111, 1'b0, 16'h0000, 1'b0, 2, 1});
        vt.push_back('{2'd0, 16'hFFFF, 16'h0000, 1'b0, 16'h1111, 1'b0, 3, 1});
        vt.push_back('{2'd2, 16'h3050, 16'h0000, 1'b0, 16'h1111, 1'b0, 5, 2});
`ifdef LC3_MEM_PROT_EN
        vt.push_back('{2'd0, 16'h0200, 16'h0000, 1'b1, 16'h0000, 1'b1, 2, 0});
        vt.push_back('{2'd2, 16'h3040, 16'h0000, 1'b1, 16'h0000, 1'b1, 3, 1});
`else
        vt.push_back('{2'd0, 16'h0200, 16'h0000, 1'b1, 16'h0202, 1'b0, 3, 1});
        vt.push_back('{2'd2, 16'h3040, 16'h0000, 1'b1, 16'hFEFE, 1'b0, 5, 2});
`endif
        vt.push_back('{2'd0, 16'h3000, 16'h0000, 1'b1, 16'h1234, 1'b0, 3, 1});

        fork
            monitor();
        join_none

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].priv,
                 vt[i].data, vt[i].err, vt[i].lat, vt[i].strobes);
            drain();
        end

        // Read-indirect holds req_ready low from ACC1 through RESP.
        send(2'd2, 16'h3020, 16'h0000, 1'b0, 16'hA5A5, 1'b0, 5, 2);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_ready) bad++;
            @(posedge clk); #1;
        end
        chk("ready_low_during_ldi", bad, 0);
        drain();
        chk("rsp_data_held", {16'd0, rsp_data}, 32'h0000A5A5);

        // Reset in WAIT1 of a read-indirect abandons it.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = 16'h3020;
        req_priv  = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_en || rsp_valid) bad++;
            @(posedge clk); #1;
        end
        chk("abort_quiet", bad, 0);

        // Reset wins over a simultaneous request.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_addr  = 16'h3300;
        req_wdata = 16'hDEAD;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_en || !req_ready) bad++;
            @(posedge clk); #1;
        end
        chk("rst_overrides_req", bad, 0);

        // Back-to-back writes with req_valid held high.
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_addr  = 16'h3200;
        req_wdata = 16'hAAAA;
        req_priv  = 1'b0;
        sbq.push_back('{16'h0000, 1'b0, cyc + 2, 1});
        sbq.push_back('{16'h0000, 1'b0, cyc + 5, 1});
        @(posedge clk); #1;
        req_addr  = 16'h3201;
        req_wdata = 16'hBBBB;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();
        chk("b2b_mem0", {16'd0, mem[16'h3200]}, 32'h0000AAAA);
        chk("b2b_mem1", {16'd0, mem[16'h3201]}, 32'h0000BBBB);

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 SHALL have parameter SYS_TOP, default 16'h2FFF, highest system-space address.
REQ-002 SHALL have parameter IO_BASE, default 16'hFE00, lowest device-register address.
REQ-003 Ports (clock and reset first); one clock, synchronous active-high reset:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00 read (LD/LDR), 01 write (ST/STR), 10 read-indirect (LDI), 11 write-indirect (STI).
- req_addr  in  16  effective address.
- req_wdata  in  16  store data.
- req_priv  in  1  1 = user mode, 0 = supervisor.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  16  read result.
- rsp_err  out  1  access-control violation.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  16  SRAM address.
- mem_wdata  out  16  SRAM write data.
- mem_rdata  in  16  SRAM read data, valid the cycle after a read strobe.

Function
REQ-004 SHALL implement FSM states IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE.
- Handshake is req_valid & req_ready.
- Accept cycle T captures op, addr, wdata, priv.
- Inputs ignored in all other states.
REQ-006 ACC1 (T+1): mem_en=1, mem_addr=captured addr, mem_we=1 only for op 01, mem_wdata=captured wdata for op 01, else 0.
REQ-007 From ACC1, op 01 SHALL go to RESP; ops 00, 10, 11 SHALL go to WAIT1.
REQ-008 WAIT1 SHALL register mem_rdata (data for op 00, pointer for 10/11). Next state: RESP for op 00, ACC2 for 10/11.
REQ-009 ACC2: mem_en=1, mem_addr=pointer, mem_we=1 only for op 11, mem_wdata=captured wdata for op 11. Next state: WAIT2 for op 10, RESP for op 11.
REQ-010 WAIT2 SHALL register mem_rdata as the data, then go to RESP.
REQ-011 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE. No response backpressure exists.
REQ-012 Latency from accept cycle T to rsp_valid: write T+2, read T+3, write-indirect T+4, read-indirect T+5. Next accept no earlier than RESP+1.
REQ-013 rsp_data SHALL equal the read result for ops 00/10, 0 for writes or errors. It SHALL hold its value until the next RESP.
REQ-014 mem_en and mem_we SHALL be 0 in IDLE, WAIT1, WAIT2 and RESP.
REQ-015 Pointer value 16'h0000 and address 16'hFFFF SHALL be treated as ordinary addresses; no wrap or special case.

Reset
REQ-016 On rst, in the same clock edge:
- state=IDLE.
- req_ready=1 the following cycle.
- rsp_valid=0, rsp_err=0, rsp_data=0.
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-017 rst mid-transaction SHALL abandon the transaction. No response is issued and no further memory strobe occurs.
REQ-018 rst SHALL override a simultaneous req_valid; the request is not accepted.

Configuration
REQ-019 Macro LC3_MEM_PROT_EN.
- Defined: an access with captured priv=1 and target address <= SYS_TOP or >= IO_BASE is a violation. The check applies to ACC1 address and ACC2 pointer separately.
- On a violation, that phase's mem_en is suppressed, the FSM goes directly to RESP, rsp_err=1 and rsp_data=0.
- rsp_err is 0 on all other responses.
- Not defined: req_priv is ignored, rsp_err is constant 0, and no access is suppressed.

Verification
REQ-020 Read: mem[16'h3000]=16'h1234; op 00, addr 16'h3000 accepted at T -> mem_en at T+1, rsp_valid at T+3, rsp_data=16'h1234.
REQ-021 Write-indirect: mem[16'h3010]=16'h4000; op 11, addr 16'h3010, wdata 16'hBEEF -> write to 16'h4000 at T+3, rsp_valid at T+4, mem[16'h4000]=16'hBEEF.
REQ-022 Read-indirect: mem[16'h3020]=16'h5000, mem[16'h5000]=16'hA5A5 -> rsp_valid at T+5, rsp_data=16'hA5A5; req_ready=0 throughout T+1..T+5.
REQ-023 LC3_MEM_PROT_EN defined, priv=1: op 00 at 16'h0200 -> no mem_en, rsp_valid at T+2, rsp_err=1. Op 10 with pointer 16'hFE04 -> single strobe, rsp_err=1 at T+3.
REQ-024 rst asserted in WAIT1 of op 10 -> no ACC2 strobe, no rsp_valid, req_ready=1 the cycle after rst.
REQ-025 Back-to-back: req_valid held high with two writes -> the second is accepted at the first's RESP+1, and each write gets exactly one rsp_valid pulse.
